// File: rtl/ps2_key_event_ctrl_if.sv
// Key event handshake between the PS/2 front end and its consumer.
// The producer presents the FIFO head; the consumer pops it.
interface ps2_key_event_ctrl_if;
    logic       i_evt_pop;
    logic       o_evt_valid;
    logic [7:0] o_evt_code;
    logic       o_evt_break;
    logic       o_evt_ext;

    modport master (
        input  i_evt_pop,
        output o_evt_valid,
        output o_evt_code,
        output o_evt_break,
        output o_evt_ext
    );

    modport slave (
        output i_evt_pop,
        input  o_evt_valid,
        input  o_evt_code,
        input  o_evt_break,
        input  o_evt_ext
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 keyboard receiver, make/break/E0 decoder, event FIFO and
// six-digit seven-segment status display (held key, ASCII, press count).
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH       = 8,
    parameter int CNT_WIDTH        = 8,
    parameter int TIMEOUT_CYC      = 100000,
    parameter int BLANK_ON_RELEASE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_clr_n,
    input  logic                 i_ps2_clk,
    input  logic                 i_ps2_data,
    ps2_key_event_ctrl_if.master evt,
    output logic [CNT_WIDTH-1:0] o_key_count,
    output logic                 o_overflow,
    output logic                 o_frame_err,
    output logic [6:0]           o_seg0,
    output logic [6:0]           o_seg1,
    output logic [6:0]           o_seg2,
    output logic [6:0]           o_seg3,
    output logic [6:0]           o_seg4,
    output logic [6:0]           o_seg5
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_BLANK;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Set-2 scan code to ASCII; unmapped codes give 00.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] c);
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43;
            8'h23: a = 8'h44; 8'h24: a = 8'h45; 8'h2B: a = 8'h46;
            8'h34: a = 8'h47; 8'h33: a = 8'h48; 8'h43: a = 8'h49;
            8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F;
            8'h4D: a = 8'h50; 8'h15: a = 8'h51; 8'h2D: a = 8'h52;
            8'h1B: a = 8'h53; 8'h2C: a = 8'h54; 8'h3C: a = 8'h55;
            8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A; 8'h45: a = 8'h30;
            8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36;
            8'h3D: a = 8'h37; 8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Keyboard status/ack bytes that never form a key event.
    function automatic logic is_ignored(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'hAA) || (c == 8'hFA) ||
               (c == 8'hEE) || (c == 8'hFE) || (c == 8'hFF);
    endfunction

    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          ps2_fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [10:0]   frame_nxt;
    logic          frame_ok;
    logic [TW-1:0] idle_cnt;
    logic          rx_valid;
    logic [7:0]    rx_byte;

    // Bring the PS/2 pins into the i_clk domain.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], i_ps2_clk};
            dat_sync <= {dat_sync[0], i_ps2_data};
        end
    end

    assign ps2_fall  = clk_sync[2] & ~clk_sync[1];
    assign frame_nxt = {dat_sync[1], shreg};
    assign frame_ok  = ~frame_nxt[0] & frame_nxt[10] & (^frame_nxt[9:1]);

    // Shift in 11 bits per frame, validate, and abort stalled frames.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            idle_cnt    <= '0;
            rx_valid    <= 1'b0;
            rx_byte     <= '0;
            o_frame_err <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            o_frame_err <= 1'b0;
            if (ps2_fall) begin
                shreg    <= frame_nxt[10:1];
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= frame_nxt[8:1];
                    end else begin
                        o_frame_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == TMO_LAST) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    dec_state_t st;
    dec_state_t st_nxt;
    logic       emit;
    logic       emit_brk;
    logic       emit_ext;

    // Decoder state register.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) st <= ST_IDLE;
        else          st <= st_nxt;
    end

    // Prefix tracking and event emission, one good byte per step.
    always_comb begin
        st_nxt   = st;
        emit     = 1'b0;
        emit_brk = 1'b0;
        emit_ext = 1'b0;
        if (rx_valid) begin
            unique case (st)
                ST_IDLE: begin
                    if (rx_byte == 8'hE0)      st_nxt = ST_EXT;
                    else if (rx_byte == 8'hF0) st_nxt = ST_BRK;
                    else if (!is_ignored(rx_byte)) emit = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte == 8'hF0) begin
                        st_nxt = ST_EXT_BRK;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        st_nxt   = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    st_nxt   = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    emit_ext = 1'b1;
                    st_nxt   = ST_IDLE;
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] occ;
    logic        full;
    logic        empty;
    logic        do_pop;
    logic        do_push;
    logic [9:0]  head;

    assign full    = (occ == DEPTH_L);
    assign empty   = (occ == '0);
    assign do_pop  = evt.i_evt_pop & ~empty;
    assign do_push = emit & (~full | do_pop);
    assign head    = mem[rd_ptr];

    assign evt.o_evt_valid = ~empty;
    assign evt.o_evt_ext   = head[9];
    assign evt.o_evt_break = head[8];
    assign evt.o_evt_code  = head[7:0];

    // Event storage; contents are only meaningful below occ.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= {emit_ext, emit_brk, rx_byte};
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      occ <= occ + 1'b1;
            else if (!do_push && do_pop) occ <= occ - 1'b1;
            if (emit && !do_push) o_overflow <= 1'b1;
        end
    end

    logic       held_valid;
    logic [8:0] held_key;
    logic [8:0] evt_key;
    logic       key_new;
    logic       key_rel;
    logic [3:0] bcd_lo;
    logic [3:0] bcd_hi;
    logic [7:0] held_ascii;

    assign evt_key    = {emit_ext, rx_byte};
    assign key_new    = emit & ~emit_brk &
                        (~held_valid | (evt_key != held_key));
    assign key_rel    = emit & emit_brk & held_valid &
                        (evt_key == held_key);
    assign held_ascii = scan_to_ascii(held_key[7:0]);

    // Held key and press counters, fed from decoder emits.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            held_valid  <= 1'b0;
            held_key    <= '0;
            o_key_count <= '0;
            bcd_lo      <= '0;
            bcd_hi      <= '0;
        end else if (key_new) begin
            held_valid  <= 1'b1;
            held_key    <= evt_key;
            o_key_count <= o_key_count + 1'b1;
            if (bcd_lo == 4'd9) begin
                bcd_lo <= '0;
                bcd_hi <= (bcd_hi == 4'd9) ? 4'd0 : bcd_hi + 4'd1;
            end else begin
                bcd_lo <= bcd_lo + 4'd1;
            end
        end else if (key_rel) begin
            held_valid <= 1'b0;
        end
    end

    // Registered display, one cycle behind the held-key state.
    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            o_seg0 <= SEG_BLANK;
            o_seg1 <= SEG_BLANK;
            o_seg2 <= SEG_BLANK;
            o_seg3 <= SEG_BLANK;
            o_seg4 <= SEG_ZERO;
            o_seg5 <= SEG_ZERO;
        end else begin
            if (held_valid) begin
                o_seg0 <= hex7(held_key[3:0]);
                o_seg1 <= hex7(held_key[7:4]);
                o_seg2 <= hex7(held_ascii[3:0]);
                o_seg3 <= hex7(held_ascii[7:4]);
            end else if (BLANK_ON_RELEASE != 0) begin
                o_seg0 <= SEG_BLANK;
                o_seg1 <= SEG_BLANK;
                o_seg2 <= SEG_BLANK;
                o_seg3 <= SEG_BLANK;
            end
            o_seg4 <= hex7(bcd_lo);
            o_seg5 <= hex7(bcd_hi);
        end
    end

endmodule
